// File: rtl/hicore_rob.sv
// hicore_rob -- in-order reorder buffer for the HiCore pipeline.
//
// Entries are allocated at decode in program order, marked done out of order
// by writeback, and retired strictly in order from the head, at most one per
// cycle. A retiring entry that raised an exception or is a fence.i or mret
// raises flush, which empties the whole buffer on the next edge.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rob_*  (in)         allocation request from decode (rob_wen = strobe)
//   rob_tail_ptr        slot index the next allocation will occupy
//   rs1/rs2/csr query   RAW hazard lookup against in-flight entries -> depend
//   empty, full         occupancy status
//   wb_*                result writeback into slot wb_ptr
//   cmt_*               retirement of the head entry (combinational)
//   flush, flush_pc     pipeline redirect when the head entry retires
module hicore_rob #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  // allocation
  input  logic             rob_wen,
  input  logic             rob_rd_need,
  input  logic [4:0]       rob_rd_idx,
  input  logic             rob_csr_need,
  input  logic [11:0]      rob_csr_idx,
  input  logic [31:0]      rob_next_pc,
  input  logic             rob_fence_i_op,
  input  logic             rob_mret_op,
  output logic [PTR_W-1:0] rob_tail_ptr,
  // dependency query
  input  logic             rs1_need,
  input  logic             rs2_need,
  input  logic [4:0]       rob_rs1_idx,
  input  logic [4:0]       rob_rs2_idx,
  input  logic             csr_need,
  input  logic [11:0]      csr_idx,
  output logic             depend,
  output logic             empty,
  output logic             full,
  // writeback
  input  logic             wb_valid,
  input  logic [PTR_W-1:0] wb_ptr,
  input  logic             wb_excp,
  input  logic [31:0]      wb_rd_dat,
  input  logic [31:0]      wb_csr_dat,
  // commit
  output logic             cmt_valid,
  output logic [PTR_W-1:0] cmt_ptr,
  output logic             cmt_rd_wen,
  output logic [4:0]       cmt_rd_idx,
  output logic [31:0]      cmt_rd_dat,
  output logic             cmt_csr_wen,
  output logic [11:0]      cmt_csr_idx,
  output logic [31:0]      cmt_csr_dat,
  output logic             cmt_excp,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  // pointers and occupancy
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // per-entry control state (reset)
  logic [DEPTH-1:0] vld_q, done_q, excp_q;

  // per-entry payload (no reset needed: only read behind vld/done)
  logic [DEPTH-1:0] rd_need_q, csr_need_q, fence_i_q, mret_q;
  logic [4:0]       rd_idx_q  [DEPTH];
  logic [11:0]      csr_idx_q [DEPTH];
  logic [31:0]      npc_q     [DEPTH];
  logic [31:0]      rd_dat_q  [DEPTH];
  logic [31:0]      csr_dat_q [DEPTH];

  logic alloc, wb_hit, commit;
  logic [DEPTH-1:0] dep_hit;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == (PTR_W+1)'(DEPTH));
  assign rob_tail_ptr = tail_q;

  // ---------------- commit view of the head entry ----------------
  assign cmt_valid = vld_q[head_q] & done_q[head_q];
  assign cmt_ptr   = head_q;
  assign cmt_excp  = cmt_valid & excp_q[head_q];
  assign flush     = cmt_valid & (excp_q[head_q] | fence_i_q[head_q] | mret_q[head_q]);
  assign flush_pc  = flush ? npc_q[head_q] : '0;

  assign cmt_rd_wen  = cmt_valid & rd_need_q[head_q] & ~excp_q[head_q]
                     & (rd_idx_q[head_q] != 5'd0);
  assign cmt_csr_wen = cmt_valid & csr_need_q[head_q] & ~excp_q[head_q];
  // payload is zeroed when nothing retires so idle outputs are clean
  assign cmt_rd_idx  = cmt_valid ? rd_idx_q[head_q]  : '0;
  assign cmt_rd_dat  = cmt_valid ? rd_dat_q[head_q]  : '0;
  assign cmt_csr_idx = cmt_valid ? csr_idx_q[head_q] : '0;
  assign cmt_csr_dat = cmt_valid ? csr_dat_q[head_q] : '0;

  // ---------------- events this cycle ----------------
  assign alloc  = rob_wen & ~full & ~flush;
  assign wb_hit = wb_valid & vld_q[wb_ptr];
  // a flushing retire does not advance head; the whole buffer is cleared
  assign commit = cmt_valid & ~flush;

  // ---------------- dependency scan ----------------
  // done-but-unretired entries still count: there is no bypass path
  for (genvar e = 0; e < DEPTH; e++) begin : g_dep
    assign dep_hit[e] = vld_q[e] & (
        (rs1_need & rd_need_q[e] & (rd_idx_q[e] == rob_rs1_idx) & (rob_rs1_idx != 5'd0))
      | (rs2_need & rd_need_q[e] & (rd_idx_q[e] == rob_rs2_idx) & (rob_rs2_idx != 5'd0))
      | (csr_need & csr_need_q[e] & (csr_idx_q[e] == csr_idx)));
  end
  assign depend = |dep_hit;

  // ---------------- pointer / count next state ----------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (alloc)  tail_d = tail_q + PTR_W'(1);
      if (commit) head_d = head_q + PTR_W'(1);
      case ({alloc, commit})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // ---------------- control state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      done_q <= '0;
      excp_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (flush) begin
        vld_q  <= '0;
        done_q <= '0;
      end else begin
        if (wb_hit) begin
          done_q[wb_ptr] <= 1'b1;
          excp_q[wb_ptr] <= wb_excp;
        end
        if (commit) begin
          vld_q[head_q]  <= 1'b0;
          done_q[head_q] <= 1'b0;
        end
        // tail never equals a committing head here: full blocks alloc
        if (alloc) begin
          vld_q[tail_q]  <= 1'b1;
          done_q[tail_q] <= 1'b0;
          excp_q[tail_q] <= 1'b0;
        end
      end
    end
  end

  // ---------------- payload ----------------
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (alloc) begin
        rd_need_q[tail_q]  <= rob_rd_need;
        rd_idx_q[tail_q]   <= rob_rd_idx;
        csr_need_q[tail_q] <= rob_csr_need;
        csr_idx_q[tail_q]  <= rob_csr_idx;
        npc_q[tail_q]      <= rob_next_pc;
        fence_i_q[tail_q]  <= rob_fence_i_op;
        mret_q[tail_q]     <= rob_mret_op;
      end
      if (wb_hit) begin
        rd_dat_q[wb_ptr]  <= wb_rd_dat;
        csr_dat_q[wb_ptr] <= wb_csr_dat;
      end
    end
  end

endmodule

// File: tb/tb_hicore_rob.sv
module tb_hicore_rob;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rob_wen, rob_rd_need, rob_csr_need, rob_fence_i_op, rob_mret_op;
  logic [4:0] rob_rd_idx, rob_rs1_idx, rob_rs2_idx;
  logic [11:0] rob_csr_idx, csr_idx;
  logic [31:0] rob_next_pc, wb_rd_dat, wb_csr_dat;
  logic rs1_need, rs2_need, csr_need, wb_valid, wb_excp;
  logic [PTR_W-1:0] wb_ptr, rob_tail_ptr, cmt_ptr;
  logic depend, empty, full, cmt_valid, cmt_rd_wen, cmt_csr_wen, cmt_excp, flush;
  logic [4:0] cmt_rd_idx;
  logic [11:0] cmt_csr_idx;
  logic [31:0] cmt_rd_dat, cmt_csr_dat, flush_pc;

  hicore_rob #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .rob_wen(rob_wen), .rob_rd_need(rob_rd_need), .rob_rd_idx(rob_rd_idx),
    .rob_csr_need(rob_csr_need), .rob_csr_idx(rob_csr_idx), .rob_next_pc(rob_next_pc),
    .rob_fence_i_op(rob_fence_i_op), .rob_mret_op(rob_mret_op), .rob_tail_ptr(rob_tail_ptr),
    .rs1_need(rs1_need), .rs2_need(rs2_need), .rob_rs1_idx(rob_rs1_idx),
    .rob_rs2_idx(rob_rs2_idx), .csr_need(csr_need), .csr_idx(csr_idx),
    .depend(depend), .empty(empty), .full(full),
    .wb_valid(wb_valid), .wb_ptr(wb_ptr), .wb_excp(wb_excp),
    .wb_rd_dat(wb_rd_dat), .wb_csr_dat(wb_csr_dat),
    .cmt_valid(cmt_valid), .cmt_ptr(cmt_ptr), .cmt_rd_wen(cmt_rd_wen),
    .cmt_rd_idx(cmt_rd_idx), .cmt_rd_dat(cmt_rd_dat), .cmt_csr_wen(cmt_csr_wen),
    .cmt_csr_idx(cmt_csr_idx), .cmt_csr_dat(cmt_csr_dat), .cmt_excp(cmt_excp),
    .flush(flush), .flush_pc(flush_pc)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model: in-order list of live entries ----------------
  typedef struct {
    int        slot;
    bit        rd_need;
    bit [4:0]  rd_idx;
    bit        csr_need;
    bit [11:0] csr_idx;
    bit [31:0] npc;
    bit        fi, mr, done, excp;
    bit [31:0] rdd, csrd;
  } ent_t;

  ent_t mq[$];
  int   m_head, m_tail;

  function automatic bit m_depend();
    foreach (mq[i]) begin
      if (rs1_need && mq[i].rd_need && mq[i].rd_idx == rob_rs1_idx && rob_rs1_idx != 0) return 1;
      if (rs2_need && mq[i].rd_need && mq[i].rd_idx == rob_rs2_idx && rob_rs2_idx != 0) return 1;
      if (csr_need && mq[i].csr_need && mq[i].csr_idx == csr_idx) return 1;
    end
    return 0;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic mdl_edge();
    ent_t n;
    bit cv, fl, al;
    if (rst) begin
      mq.delete(); m_head = 0; m_tail = 0;
      return;
    end
    cv = mq.size() > 0 && mq[0].done;
    fl = cv && (mq[0].excp || mq[0].fi || mq[0].mr);
    if (fl) begin
      mq.delete(); m_head = 0; m_tail = 0;
      return;
    end
    al = rob_wen && mq.size() < DEPTH;
    if (wb_valid)
      foreach (mq[i])
        if (mq[i].slot == int'(wb_ptr)) begin
          mq[i].done = 1; mq[i].excp = wb_excp; mq[i].rdd = wb_rd_dat; mq[i].csrd = wb_csr_dat;
        end
    if (cv) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (al) begin
      n = '{default: 0};
      n.slot = m_tail; n.rd_need = rob_rd_need; n.rd_idx = rob_rd_idx;
      n.csr_need = rob_csr_need; n.csr_idx = rob_csr_idx; n.npc = rob_next_pc;
      n.fi = rob_fence_i_op; n.mr = rob_mret_op;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drv_idle();
    rst = 0; rob_wen = 0; rob_rd_need = 0; rob_rd_idx = 0; rob_csr_need = 0;
    rob_csr_idx = 0; rob_next_pc = 0; rob_fence_i_op = 0; rob_mret_op = 0;
    rs1_need = 0; rs2_need = 0; rob_rs1_idx = 0; rob_rs2_idx = 0; csr_need = 0; csr_idx = 0;
    wb_valid = 0; wb_ptr = 0; wb_excp = 0; wb_rd_dat = 0; wb_csr_dat = 0;
  endtask

  // inputs change 1 time unit after the edge, checks land 1 unit later
  task automatic tick();
    mdl_edge();
    @(posedge clk);
    #1;
    drv_idle();
  endtask

  task automatic do_reset();
    drv_idle();
    rst = 1;
    tick();
  endtask

  task automatic set_alloc(input bit rn, input bit [4:0] ri, input bit cn, input bit [11:0] ci,
                           input bit [31:0] pc, input bit fi, input bit mr);
    rob_wen = 1; rob_rd_need = rn; rob_rd_idx = ri; rob_csr_need = cn; rob_csr_idx = ci;
    rob_next_pc = pc; rob_fence_i_op = fi; rob_mret_op = mr;
  endtask

  task automatic set_wb(input bit [2:0] p, input bit ex, input bit [31:0] rd, input bit [31:0] cs);
    wb_valid = 1; wb_ptr = p; wb_excp = ex; wb_rd_dat = rd; wb_csr_dat = cs;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drv_idle();
    rst = 1;
    set_alloc(1, 5, 1, 12'h300, 32'h10, 0, 0);
    tick();
    rs1_need = 1; rob_rs1_idx = 5; csr_need = 1; csr_idx = 12'h300;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (depend !== 1'b0) begin failures++; $display("FAIL reset_depend got=%0b exp=0", depend); end
    checks++; if (cmt_valid !== 1'b0) begin failures++; $display("FAIL reset_cmt_valid got=%0b exp=0", cmt_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    checks++; if (rob_tail_ptr !== 3'd0) begin failures++; $display("FAIL reset_tail got=%0d exp=0", rob_tail_ptr); end
    checks++; if (cmt_ptr !== 3'd0) begin failures++; $display("FAIL reset_cmt_ptr got=%0d exp=0", cmt_ptr); end
    checks++; if ({cmt_rd_wen, cmt_csr_wen, cmt_excp, cmt_rd_idx, cmt_rd_dat, cmt_csr_idx, cmt_csr_dat, flush_pc} !== '0) begin
      failures++; $display("FAIL reset_cmt_fields got nonzero exp=0");
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, 5'($urandom_range(1, 31)), 0, 0, $urandom, 0, 0);
      #1;
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_not_full i=%0d got=%0b exp=0", i, full); end
      tick();
    end
    #1;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
    checks++; if (rob_tail_ptr !== 3'd0) begin failures++; $display("FAIL fill_tail_wrap got=%0d exp=0", rob_tail_ptr); end
    set_alloc(1, 3, 0, 0, 32'hdead, 0, 0);  // ninth alloc must be ignored
    tick();
    #1;
    checks++; if (rob_tail_ptr !== 3'd0) begin failures++; $display("FAIL fill_9th_tail got=%0d exp=0", rob_tail_ptr); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_9th_full got=%0b exp=1", full); end
  endtask

  task automatic test_dependency();
    do_reset();
    set_alloc(1, 5, 1, 12'h300, 32'h100, 0, 0); tick();
    set_alloc(1, 0, 0, 0, 32'h104, 0, 0); tick();
    rs1_need = 1; rob_rs1_idx = 5; #1;
    checks++; if (depend !== 1'b1) begin failures++; $display("FAIL dep_rs1_hit got=%0b exp=1", depend); end
    rob_rs1_idx = 0; #1;
    checks++; if (depend !== 1'b0) begin failures++; $display("FAIL dep_x0 got=%0b exp=0", depend); end
    rs1_need = 0; rs2_need = 1; rob_rs2_idx = 5; #1;
    checks++; if (depend !== 1'b1) begin failures++; $display("FAIL dep_rs2_hit got=%0b exp=1", depend); end
    rs2_need = 0; csr_need = 1; csr_idx = 12'h300; #1;
    checks++; if (depend !== 1'b1) begin failures++; $display("FAIL dep_csr_hit got=%0b exp=1", depend); end
    csr_idx = 12'h301; #1;
    checks++; if (depend !== 1'b0) begin failures++; $display("FAIL dep_csr_miss got=%0b exp=0", depend); end
    set_wb(0, 0, 32'h55, 0); tick();
    rs1_need = 1; rob_rs1_idx = 5; #1;
    checks++; if (depend !== 1'b1) begin failures++; $display("FAIL dep_done_nobypass got=%0b exp=1", depend); end
    tick();  // entry 0 retires on this edge
    rs1_need = 1; rob_rs1_idx = 5; #1;
    checks++; if (depend !== 1'b0) begin failures++; $display("FAIL dep_after_commit got=%0b exp=0", depend); end
  endtask

  task automatic test_ooo_wb();
    bit [31:0] da, db;
    da = $urandom; db = $urandom;
    do_reset();
    set_alloc(1, 7, 0, 0, 32'h200, 0, 0); tick();
    set_alloc(1, 9, 0, 0, 32'h204, 0, 0); tick();
    set_wb(1, 0, da, 0); #1;
    checks++; if (cmt_valid !== 1'b0) begin failures++; $display("FAIL ooo_no_commit got=%0b exp=0", cmt_valid); end
    tick();
    set_wb(0, 0, db, 0); #1;
    checks++; if (cmt_valid !== 1'b0) begin failures++; $display("FAIL ooo_wb_head_same_cycle got=%0b exp=0", cmt_valid); end
    tick(); #1;
    checks++; if (cmt_valid !== 1'b1 || cmt_ptr !== 3'd0) begin failures++; $display("FAIL ooo_first valid=%0b ptr=%0d exp=1/0", cmt_valid, cmt_ptr); end
    checks++; if (cmt_rd_dat !== db || cmt_rd_idx !== 5'd7 || cmt_rd_wen !== 1'b1) begin
      failures++; $display("FAIL ooo_first_data dat=%h idx=%0d wen=%0b exp=%h/7/1", cmt_rd_dat, cmt_rd_idx, cmt_rd_wen, db);
    end
    tick(); #1;
    checks++; if (cmt_valid !== 1'b1 || cmt_ptr !== 3'd1) begin failures++; $display("FAIL ooo_second valid=%0b ptr=%0d exp=1/1", cmt_valid, cmt_ptr); end
    checks++; if (cmt_rd_dat !== da || cmt_rd_idx !== 5'd9) begin
      failures++; $display("FAIL ooo_second_data dat=%h idx=%0d exp=%h/9", cmt_rd_dat, cmt_rd_idx, da);
    end
    tick(); #1;
    checks++; if (empty !== 1'b1 || cmt_valid !== 1'b0) begin failures++; $display("FAIL ooo_drained empty=%0b valid=%0b exp=1/0", empty, cmt_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    set_alloc(0, 0, 0, 0, 32'h80000100, 0, 1); tick();
    set_alloc(1, 4, 0, 0, 32'h80000200, 0, 0); tick();
    set_alloc(1, 6, 0, 0, 32'h80000204, 0, 0); tick();
    set_wb(2, 0, 1, 0); tick();
    set_wb(1, 0, 2, 0); #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_early got=%0b exp=0", flush); end
    tick();
    set_wb(0, 0, 3, 0); tick();
    set_alloc(1, 8, 0, 0, 32'h1, 0, 0);  // discarded by the flush
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL flush_raise got=%0b exp=1", flush); end
    checks++; if (flush_pc !== 32'h80000100) begin failures++; $display("FAIL flush_pc got=%h exp=80000100", flush_pc); end
    tick(); #1;
    checks++; if (empty !== 1'b1 || rob_tail_ptr !== 3'd0) begin failures++; $display("FAIL flush_after empty=%0b tail=%0d exp=1/0", empty, rob_tail_ptr); end
    checks++; if (flush !== 1'b0 || cmt_valid !== 1'b0) begin failures++; $display("FAIL flush_after_idle flush=%0b valid=%0b exp=0/0", flush, cmt_valid); end
  endtask

  task automatic test_exception();
    do_reset();
    set_alloc(1, 3, 0, 0, 32'h1234, 0, 0); tick();
    set_wb(0, 1, 32'hcafe, 0); tick(); #1;
    checks++; if (cmt_excp !== 1'b1) begin failures++; $display("FAIL excp_flag got=%0b exp=1", cmt_excp); end
    checks++; if (cmt_rd_wen !== 1'b0) begin failures++; $display("FAIL excp_rd_wen got=%0b exp=0", cmt_rd_wen); end
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h1234) begin failures++; $display("FAIL excp_flush got=%0b pc=%h exp=1/1234", flush, flush_pc); end
    tick(); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL excp_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_alloc_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin set_alloc(1, 5'(i + 1), 0, 0, 0, 0, 0); tick(); end
    set_wb(0, 0, 32'h77, 0); tick();
    set_alloc(1, 10, 0, 0, 0, 0, 0); #1;
    checks++; if (cmt_valid !== 1'b1) begin failures++; $display("FAIL ac_cmt_valid got=%0b exp=1", cmt_valid); end
    tick(); #1;
    checks++; if (rob_tail_ptr !== 3'd4 || cmt_ptr !== 3'd1) begin failures++; $display("FAIL ac_ptrs tail=%0d head=%0d exp=4/1", rob_tail_ptr, cmt_ptr); end
    // count held at 3, so exactly five more allocs fill the buffer
    for (int i = 0; i < 5; i++) begin
      set_alloc(0, 0, 0, 0, 0, 0, 0); tick(); #1;
      checks++; if (full !== (i == 4)) begin failures++; $display("FAIL ac_count_fill i=%0d got=%0b exp=%0b", i, full, i == 4); end
    end
    checks++; if (rob_tail_ptr !== 3'd1) begin failures++; $display("FAIL ac_tail_wrap got=%0d exp=1", rob_tail_ptr); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin set_alloc(1, 5'(i + 1), 0, 0, 0, 0, 0); tick(); end
    set_wb(0, 0, 1, 0); tick();
    rst = 1; set_alloc(1, 2, 0, 0, 0, 0, 0); set_wb(1, 0, 2, 0);
    tick(); #1;
    checks++; if (empty !== 1'b1 || rob_tail_ptr !== 3'd0) begin failures++; $display("FAIL mrst_state empty=%0b tail=%0d exp=1/0", empty, rob_tail_ptr); end
    checks++; if (cmt_valid !== 1'b0 || cmt_ptr !== 3'd0) begin failures++; $display("FAIL mrst_commit valid=%0b ptr=%0d exp=0/0", cmt_valid, cmt_ptr); end
  endtask

  task automatic test_random();
    ent_t e;
    bit   ev, efl;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 6)
        set_alloc($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
                  12'h300 + 12'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1)
        set_wb(3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0, $urandom, $urandom);
      rs1_need = $urandom_range(0, 1); rob_rs1_idx = 5'($urandom_range(0, 3));
      rs2_need = $urandom_range(0, 1); rob_rs2_idx = 5'($urandom_range(0, 3));
      csr_need = $urandom_range(0, 1); csr_idx = 12'h300 + 12'($urandom_range(0, 1));
      #1;
      ev = mq.size() > 0 && mq[0].done;
      e  = '{default: 0};
      if (ev) e = mq[0];
      efl = ev && (e.excp || e.fi || e.mr);
      checks++; if (empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, empty, mq.size() == 0); end
      checks++; if (full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, full, mq.size() == DEPTH); end
      checks++; if (rob_tail_ptr !== 3'(m_tail)) begin failures++; $display("FAIL rnd_tail c=%0d got=%0d exp=%0d", c, rob_tail_ptr, m_tail); end
      checks++; if (cmt_ptr !== 3'(m_head)) begin failures++; $display("FAIL rnd_head c=%0d got=%0d exp=%0d", c, cmt_ptr, m_head); end
      checks++; if (depend !== m_depend()) begin failures++; $display("FAIL rnd_depend c=%0d got=%0b exp=%0b", c, depend, m_depend()); end
      checks++; if (cmt_valid !== ev) begin failures++; $display("FAIL rnd_cmt_valid c=%0d got=%0b exp=%0b", c, cmt_valid, ev); end
      checks++; if (cmt_rd_wen !== (ev && e.rd_need && !e.excp && e.rd_idx != 0)) begin
        failures++; $display("FAIL rnd_rd_wen c=%0d got=%0b", c, cmt_rd_wen); end
      checks++; if (cmt_csr_wen !== (ev && e.csr_need && !e.excp)) begin
        failures++; $display("FAIL rnd_csr_wen c=%0d got=%0b", c, cmt_csr_wen); end
      checks++; if (cmt_excp !== (ev && e.excp)) begin failures++; $display("FAIL rnd_excp c=%0d got=%0b", c, cmt_excp); end
      checks++; if (ev && (cmt_rd_idx !== e.rd_idx || cmt_rd_dat !== e.rdd || cmt_csr_idx !== e.csr_idx || cmt_csr_dat !== e.csrd)) begin
        failures++; $display("FAIL rnd_cmt_data c=%0d got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", c,
          cmt_rd_idx, cmt_rd_dat, cmt_csr_idx, cmt_csr_dat, e.rd_idx, e.rdd, e.csr_idx, e.csrd);
      end
      checks++; if (flush !== efl) begin failures++; $display("FAIL rnd_flush c=%0d got=%0b exp=%0b", c, flush, efl); end
      checks++; if (flush_pc !== (efl ? e.npc : 32'd0)) begin failures++; $display("FAIL rnd_flush_pc c=%0d got=%h exp=%h", c, flush_pc, efl ? e.npc : 32'd0); end
      tick();
    end
  endtask

  initial begin
    drv_idle();
    mq.delete(); m_head = 0; m_tail = 0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_dependency();
    test_ooo_wb();
    test_flush();
    test_exception();
    test_alloc_commit();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hicore_rob.md
HICORE_ROB -- requirements
Module: hicore_rob

Interface
REQ-001 Parameter DEPTH, 8, number of ROB entries (power of 2).
REQ-002 Parameter PTR_W, 3, pointer width, equal to log2(DEPTH) (`HiCore_ROB_PTR_SIZE).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-004 Allocation inputs from decode: rob_wen 1 alloc strobe; rob_rd_need 1; rob_rd_idx 5; rob_csr_need 1; rob_csr_idx 12; rob_next_pc 32; rob_fence_i_op 1; rob_mret_op 1.
REQ-005 rob_tail_ptr output PTR_W: index the next allocation will use.
REQ-006 Dependency query inputs: rs1_need 1; rs2_need 1; rob_rs1_idx 5; rob_rs2_idx 5; csr_need 1; csr_idx 12. Outputs: depend 1, empty 1, full 1.
REQ-007 Writeback inputs: wb_valid 1; wb_ptr PTR_W; wb_excp 1 (exception raised); wb_rd_dat 32; wb_csr_dat 32.
REQ-008 Commit outputs: cmt_valid 1; cmt_ptr PTR_W; cmt_rd_wen 1; cmt_rd_idx 5; cmt_rd_dat 32; cmt_csr_wen 1; cmt_csr_idx 12; cmt_csr_dat 32; cmt_excp 1; flush 1; flush_pc 32.

Function
REQ-009 Storage is a circular buffer: head, tail (PTR_W each) and count (PTR_W+1); per entry: valid, done, excp, rd_need, rd_idx, csr_need, csr_idx, next_pc, fence_i, mret, rd_dat, csr_dat.
REQ-010 empty = (count==0), full = (count==DEPTH), both combinational from registered state; rob_tail_ptr = tail.
REQ-011 Alloc happens when rob_wen & ~full & ~flush: entry[tail] loaded with valid=1, done=0, excp=0; tail <= tail+1 mod DEPTH. rob_wen while full or while flush is ignored.
REQ-012 Writeback when wb_valid & entry[wb_ptr].valid: done<=1, excp<=wb_excp, rd_dat, csr_dat captured. Writeback to an invalid entry is ignored; a repeated writeback overwrites.
REQ-013 depend is combinational: 1 iff some valid entry satisfies (rs1_need & rd_need & rd_idx==rob_rs1_idx & rob_rs1_idx!=0) or the same for rs2, or (csr_need & entry csr_need & entry csr_idx==csr_idx). Done-but-uncommitted entries still count (no bypass).
REQ-014 Commit is combinational from head: cmt_valid = entry[head].valid & done; cmt_ptr = head; cmt_rd_wen = cmt_valid & rd_need & ~excp & rd_idx!=0; cmt_csr_wen = cmt_valid & csr_need & ~excp; data/idx fields driven from entry[head]; cmt_excp = cmt_valid & excp.
REQ-015 At most one commit per cycle; on a non-flushing commit, entry[head].valid<=0, head <= head+1 mod DEPTH.
REQ-016 flush = cmt_valid & (excp | fence_i | mret); flush_pc = entry[head].next_pc; both 0/don't-care-free (driven 0) when flush=0.
REQ-017 Flush cycle next edge: all valid bits 0, head=tail=0, count=0; allocation and writeback in that cycle are discarded.
REQ-018 Count rules: alloc only +1; commit only -1; alloc and commit same cycle unchanged; flush overrides to 0.
REQ-019 Alloc into a slot being freed by the same-cycle commit (count==DEPTH) is not allowed since full blocks alloc; full deasserts the cycle after commit.
REQ-020 Writeback and commit of different entries in the same cycle both take effect; writeback to head in the same cycle commit is evaluated is seen next cycle (commit uses registered done).

Reset
REQ-021 rst, sampled at clk edge, clears head, tail, count, all valid/done bits; afterwards empty=1, full=0, depend=0, cmt_valid=0, flush=0, all commit outputs 0, rob_tail_ptr=0.
REQ-022 rst asserted mid-operation discards all entries identically to REQ-021 and overrides any same-cycle alloc, writeback or commit.

Verification
REQ-023 Fill: 8 allocs without writeback -> full=1 after 8th edge, 9th rob_wen ignored, tail=0 (wrapped), count=8.
REQ-024 Dependency: alloc rd_need=1 rd_idx=5, query rs1 idx 5 -> depend=1; query idx 0 with rd_idx=0 entry -> depend=0; after commit -> depend=0.
REQ-025 Out-of-order writeback: alloc ptr0,ptr1; wb ptr1 then ptr0 -> commits in order ptr0 then ptr1, cmt_rd_dat matching each, one per cycle.
REQ-026 Flush: alloc mret entry next_pc=0x80000100 plus 2 younger; wb all -> flush=1 with flush_pc=0x80000100 on head commit, next cycle empty=1, tail=0.
REQ-027 Exception: wb_excp=1 on head with rd_need=1 -> cmt_excp=1, cmt_rd_wen=0, flush=1.
REQ-028 Simultaneous alloc+commit at count=3 -> count stays 3, head and tail both advance; rst mid-fill -> empty=1 next cycle.
